adc_8ch_045: RTL and testbench



---
 rtl/adc_8ch_045_pkg.sv | 26 ++
 rtl/adc_8ch_045_spi_frame.sv | 141 ++++++++++++++
 rtl/adc_8ch_045.sv | 90 +++++++++
 tb/tb_adc_8ch_045.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_8ch_045_pkg.sv
// Shared types and constants for the 8-channel SAR ADC sequencer.
// Holds the frame-engine state encoding and the ADC control-word layout.
package adc_8ch_045_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SHIFT,
        ST_END,
        ST_QUIET
    } frame_state_t;

    localparam int FRAME_LEN = 16;

    // Control-word fields: write the control register, no sequencer,
    // normal power mode, straight binary coding.
    localparam logic       WRITE  = 1'b1;
    localparam logic       SEQ    = 1'b0;
    localparam logic [1:0] PM     = 2'b11;
    localparam logic       CODING = 1'b1;

    function automatic logic [FRAME_LEN-1:0] ctrl_word(input logic [2:0] next_ch);
        return {WRITE, SEQ, next_ch, PM, 1'b0, 1'b0, 1'b0, CODING, 5'b0_0000};
    endfunction

endpackage

// File: rtl/adc_8ch_045_spi_frame.sv
// One SPI frame to the ADC: CS low, 16 SCLK periods, CS high, then a quiet gap.
// Pulses done with the received word at the end of the frame, quiet_done after the gap.
module adc_8ch_045_spi_frame
    import adc_8ch_045_pkg::*;
#(
    parameter int SCLK_DIV = 2,
    parameter int CS_QUIET = 4
) (
    input  logic                 adc_clk,
    input  logic                 rst_l,
    input  logic                 start,
    input  logic [FRAME_LEN-1:0] tx_word,
    input  logic                 dout,
    output logic                 sclk,
    output logic                 cs_n,
    output logic                 din,
    output logic                 done,
    output logic                 quiet_done,
    output logic [FRAME_LEN-1:0] rx_word,
    output frame_state_t         state
);

    localparam int CNT_MAX = (SCLK_DIV > CS_QUIET) ? SCLK_DIV : CS_QUIET;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int BIT_W   = $clog2(FRAME_LEN);

    frame_state_t         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 sclk_q, sclk_d;
    logic                 cs_q, cs_d;
    logic                 din_q, din_d;
    logic [FRAME_LEN-1:0] tx_q, tx_d;
    logic [FRAME_LEN-1:0] rx_q, rx_d;
    logic                 start_capture, start_capture_d;
    logic                 half_last;
    logic                 launch;

    assign half_last  = (cnt_q == CNT_W'(SCLK_DIV - 1));
    assign done       = (state_q == ST_END) && half_last;
    assign quiet_done = (state_q == ST_QUIET) && (cnt_q == CNT_W'(CS_QUIET - 1));
    assign launch     = start && ((state_q == ST_IDLE) || quiet_done);

    always_ff @(posedge adc_clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bit_q         <= '0;
            sclk_q        <= 1'b1;
            cs_q          <= 1'b1;
            din_q         <= 1'b0;
            tx_q          <= '0;
            rx_q          <= '0;
            start_capture <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            sclk_q        <= sclk_d;
            cs_q          <= cs_d;
            din_q         <= din_d;
            tx_q          <= tx_d;
            rx_q          <= rx_d;
            start_capture <= start_capture_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q + CNT_W'(1);
        bit_d           = bit_q;
        sclk_d          = sclk_q;
        cs_d            = cs_q;
        din_d           = din_q;
        tx_d            = tx_q;
        rx_d            = rx_q;
        start_capture_d = 1'b0;

        case (state_q)
            ST_IDLE: cnt_d = '0;
            ST_START: begin
                if (start_capture) rx_d = '0;
                if (half_last) begin
                    // First falling edge: present bit 15 on DIN.
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                    din_d   = tx_q[FRAME_LEN-1];
                    tx_d    = {tx_q[FRAME_LEN-2:0], 1'b0};
                end
            end
            ST_SHIFT: begin
                if (half_last) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[FRAME_LEN-2:0], dout};
                    end else if (bit_q == BIT_W'(FRAME_LEN - 1)) begin
                        state_d = ST_END;
                    end else begin
                        sclk_d = 1'b0;
                        din_d  = tx_q[FRAME_LEN-1];
                        tx_d   = {tx_q[FRAME_LEN-2:0], 1'b0};
                        bit_d  = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_END: begin
                if (half_last) begin
                    state_d = ST_QUIET;
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                end
            end
            ST_QUIET: begin
                if (quiet_done) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new frame may start straight out of the quiet gap without an idle cycle.
        if (launch) begin
            state_d         = ST_START;
            cnt_d           = '0;
            cs_d            = 1'b0;
            tx_d            = tx_word;
            start_capture_d = 1'b1;
        end
    end

    assign sclk    = sclk_q;
    assign cs_n    = cs_q;
    assign din     = din_q;
    assign rx_word = rx_q;
    assign state   = state_q;

endmodule

// File: rtl/adc_8ch_045.sv
// Sweep sequencer: on sync, converts channels 0..N_CH-1 one SPI frame each
// and streams the 12-bit results with their channel number.
module adc_8ch_045
    import adc_8ch_045_pkg::*;
#(
    parameter int SCLK_DIV = 2,
    parameter int CS_QUIET = 4,
    parameter int N_CH     = 8
) (
    input  logic        adc_clk,
    input  logic        rst_l,
    input  logic        sync,
    input  logic        DOUT,
    output logic        SCLK,
    output logic        CS_ADC,
    output logic        CD_MUX,
    output logic        DIN,
    output logic [2:0]  channel,
    output logic [11:0] sample,
    output logic [2:0]  sample_ch,
    output logic        sample_valid,
    output logic        busy
);

    logic                 frame_start;
    logic                 frame_done;
    logic                 frame_quiet_done;
    logic [FRAME_LEN-1:0] frame_rx;
    frame_state_t         frame_state;
    logic [2:0]           frame_ch;
    logic                 last_ch;
    logic                 accept;
    logic                 unused_msbs;

    assign last_ch     = (channel == 3'(N_CH - 1));
    assign accept      = sync && !busy && (frame_state == ST_IDLE);
    assign frame_start = accept || (frame_quiet_done && !last_ch);
    // Channel the frame being launched will convert; the word addresses the one after it.
    assign frame_ch    = busy ? channel + 3'd1 : 3'd0;
    assign unused_msbs = ^frame_rx[FRAME_LEN-1:12];

    adc_8ch_045_spi_frame #(
        .SCLK_DIV (SCLK_DIV),
        .CS_QUIET (CS_QUIET)
    ) u_frame (
        .adc_clk    (adc_clk),
        .rst_l      (rst_l),
        .start      (frame_start),
        .tx_word    (ctrl_word(frame_ch + 3'd1)),
        .dout       (DOUT),
        .sclk       (SCLK),
        .cs_n       (CS_ADC),
        .din        (DIN),
        .done       (frame_done),
        .quiet_done (frame_quiet_done),
        .rx_word    (frame_rx),
        .state      (frame_state)
    );

    always_ff @(posedge adc_clk or negedge rst_l) begin
        if (!rst_l) begin
            channel      <= 3'd0;
            busy         <= 1'b0;
            CD_MUX       <= 1'b1;
            sample       <= 12'd0;
            sample_ch    <= 3'd0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= frame_done;
            if (frame_done) begin
                sample    <= frame_rx[11:0];
                sample_ch <= channel;
            end
            if (accept) begin
                busy    <= 1'b1;
                CD_MUX  <= 1'b0;
                channel <= 3'd0;
            end else if (frame_quiet_done) begin
                if (last_ch) begin
                    busy    <= 1'b0;
                    CD_MUX  <= 1'b1;
                    channel <= 3'd0;
                end else begin
                    channel <= channel + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_8ch_045.sv
// Directed bench for adc_8ch_045 with a behavioural ADC returning 12'h123+ch,
// bus monitors on the negative clock edge and immediate-assertion checks.
module tb_adc_8ch_045;

    logic        adc_clk = 1'b0;
    logic        rst_l   = 1'b0;
    logic        sync    = 1'b0;
    logic        DOUT    = 1'b0;
    logic        SCLK, CS_ADC, CD_MUX, DIN, sample_valid, busy;
    logic [2:0]  channel, sample_ch;
    logic [11:0] sample;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 adc_clk = ~adc_clk;

    adc_8ch_045 dut (
        .adc_clk      (adc_clk),
        .rst_l        (rst_l),
        .sync         (sync),
        .DOUT         (DOUT),
        .SCLK         (SCLK),
        .CS_ADC       (CS_ADC),
        .CD_MUX       (CD_MUX),
        .DIN          (DIN),
        .channel      (channel),
        .sample       (sample),
        .sample_ch    (sample_ch),
        .sample_valid (sample_valid),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ADC model: result 12'h123 + frame index after four zero bits, changing on SCLK fall.
    logic [3:0]  model_ch = 4'd0;
    logic [15:0] model_word;
    int          adc_bit = 0;
    always @(negedge CS_ADC) adc_bit = 0;
    always @(posedge CS_ADC) model_ch = model_ch + 4'd1;
    always @(negedge SCLK) begin
        if (CS_ADC === 1'b0 && adc_bit < 16) begin
            model_word = {4'h0, 12'h123 + {8'h00, model_ch}};
            DOUT = model_word[15 - adc_bit];
            adc_bit++;
        end
    end

    // Bus monitor
    logic        prev_sclk = 1'b1;
    logic        prev_cs   = 1'b1;
    int          fall_cnt  = 0;
    logic [15:0] din_sh    = '0;
    logic [2:0]  frame_ch  = '0;
    bit          chan_bad  = 1'b0;
    int          falls_q[$];
    logic [15:0] din_q[$];
    logic [2:0]  ch_q[$];
    logic [14:0] got_q[$];

    always @(negedge adc_clk) begin
        if (CS_ADC === 1'b0 && prev_cs === 1'b1) begin
            fall_cnt = 0;
            frame_ch = channel;
        end
        if (CS_ADC === 1'b0 && channel !== frame_ch) chan_bad = 1'b1;
        if (CS_ADC === 1'b0 && prev_sclk === 1'b1 && SCLK === 1'b0) begin
            fall_cnt++;
            din_sh = {din_sh[14:0], DIN};
        end
        if (CS_ADC === 1'b1 && prev_cs === 1'b0) begin
            falls_q.push_back(fall_cnt);
            din_q.push_back(din_sh);
            ch_q.push_back(frame_ch);
        end
        if (sample_valid === 1'b1) got_q.push_back({sample_ch, sample});
        prev_sclk = SCLK;
        prev_cs   = CS_ADC;
    end

    task automatic clear_logs();
        falls_q.delete();
        din_q.delete();
        ch_q.delete();
        got_q.delete();
        chan_bad = 1'b0;
        model_ch = 4'd0;
    endtask

    int          t;
    int          done_t;
    bit          hit;
    logic [15:0] exp_word;
    logic [14:0] exp_q[$];

    initial begin
        // Reset values
        repeat (3) @(negedge adc_clk);
        check("rst_sclk", SCLK, 1);
        check("rst_cs", CS_ADC, 1);
        check("rst_cd_mux", CD_MUX, 1);
        check("rst_din", DIN, 0);
        check("rst_channel", channel, 0);
        check("rst_sample", sample, 0);
        check("rst_sample_ch", sample_ch, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_start_capture", dut.u_frame.start_capture, 0);

        rst_l = 1'b1;
        repeat (3) @(negedge adc_clk);
        check("idle_cs", CS_ADC, 1);
        clear_logs();

        // Full sweep with two syncs arriving mid-sweep
        sync = 1'b1;
        @(negedge adc_clk);
        sync = 1'b0;
        check("sync_cs_low", CS_ADC, 0);
        check("sync_cd_mux_low", CD_MUX, 0);
        check("sync_busy", busy, 1);
        check("sync_channel", channel, 0);
        check("sync_sclk_high", SCLK, 1);
        check("start_capture_pulse", dut.u_frame.start_capture, 1);
        @(negedge adc_clk);
        check("start_capture_drop", dut.u_frame.start_capture, 0);
        check("first_fall_pending", SCLK, 1);
        @(negedge adc_clk);
        check("first_fall", SCLK, 0);

        t = 3;
        done_t = 0;
        while (t < 800 && done_t == 0) begin
            @(negedge adc_clk);
            t++;
            if (busy === 1'b0) done_t = t;
            sync = (t == 100 || t == 300);
        end
        sync = 1'b0;
        check("sweep_len", done_t, 577);
        check("end_cd_mux", CD_MUX, 1);
        check("end_channel", channel, 0);

        for (int i = 0; i < 8; i++) exp_q.push_back({3'(i), 12'h123 + 12'(i)});
        check("n_samples", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) check($sformatf("sample_%0d", i), got_q[i], exp_q[i]);
        exp_q.delete();

        check("n_frames", falls_q.size(), 8);
        for (int i = 0; i < 8 && i < falls_q.size(); i++) begin
            check($sformatf("falls_%0d", i), falls_q[i], 16);
            check($sformatf("frame_ch_%0d", i), ch_q[i], i);
            exp_word = {1'b1, 1'b0, 3'(i + 1), 2'b11, 3'b000, 1'b1, 5'b00000};
            check($sformatf("din_%0d", i), din_q[i], exp_word);
        end
        if (din_q.size() > 3) check("din_ch3", din_q[3], 16'b1_0_100_11_0_0_0_1_00000);
        check("channel_stable", chan_bad, 0);

        // No queued sweep from the ignored syncs
        repeat (100) @(negedge adc_clk);
        check("no_extra_busy", busy, 0);
        check("no_extra_samples", got_q.size(), 8);

        // Reset during frame 4 after the 9th SCLK fall
        clear_logs();
        sync = 1'b1;
        @(negedge adc_clk);
        sync = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 1000 && !hit; k++) begin
            @(negedge adc_clk);
            #1;
            if (ch_q.size() == 4 && CS_ADC === 1'b0 && fall_cnt == 9) hit = 1'b1;
        end
        check("abort_point_reached", hit, 1);
        check("abort_frame_channel", channel, 4);
        rst_l = 1'b0;
        #1;
        check("abort_sclk", SCLK, 1);
        check("abort_cs", CS_ADC, 1);
        check("abort_cd_mux", CD_MUX, 1);
        check("abort_din", DIN, 0);
        check("abort_busy", busy, 0);
        check("abort_channel", channel, 0);
        check("abort_sample", sample, 0);
        check("abort_valid", sample_valid, 0);
        repeat (5) @(negedge adc_clk);
        check("abort_no_strobe", got_q.size(), 4);
        if (got_q.size() > 3) check("abort_last_good", got_q[3], {3'd3, 12'h126});

        // Clean restart
        rst_l = 1'b1;
        repeat (3) @(negedge adc_clk);
        clear_logs();
        sync = 1'b1;
        @(negedge adc_clk);
        sync = 1'b0;
        check("restart_channel", channel, 0);
        check("restart_cs", CS_ADC, 0);
        done_t = 0;
        for (int k = 2; k < 800 && done_t == 0; k++) begin
            @(negedge adc_clk);
            if (busy === 1'b0) done_t = k;
        end
        check("restart_len", done_t, 577);
        check("restart_samples", got_q.size(), 8);
        if (got_q.size() == 8) begin
            check("restart_first", got_q[0], {3'd0, 12'h123});
            check("restart_last", got_q[7], {3'd7, 12'h12A});
        end
        check("restart_channel_stable", chan_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
